ccsds123_out_buffer: RTL and testbench
======================================

Name: ccsds123_out_buffer

Overview:
- Receiver for the compressor's packed output stream (out_tdata/out_tvalid/out_tlast), which has no backpressure.
- Absorbs beats into a FIFO and re-presents them as an AXI4-Stream master with tready, so DMA or interconnect sinks can stall.
- Reports per-frame word counts and a sticky overflow flag, so lost data is detected instead of silently corrupting the bitstream.

Parameters:
- BUS_WIDTH, 64, width of the compressed-data bus in bits; multiple of 8.
- DEPTH_LOG, 5, log2 of FIFO depth in beats (default depth 32).
- AF_MARGIN, 4, almost_full asserts when free entries <= AF_MARGIN.
- CNT_W, 32, width of the frame word counter and drop counter.

Ports:
- clk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- in_tdata  in  BUS_WIDTH  compressed word from ccsds123_top out_tdata.
- in_tvalid  in  1  beat present; no ready is returned.
- in_tlast  in  1  last word of a compressed image.
- m_tdata  out  BUS_WIDTH  buffered word.
- m_tvalid  out  1  buffered word available.
- m_tready  in  1  downstream accepts.
- m_tlast  out  1  tlast carried with the word.
- level  out  DEPTH_LOG+1  current FIFO occupancy (0..2^DEPTH_LOG).
- almost_full  out  1  registered; free entries <= AF_MARGIN.
- overflow  out  1  sticky; at least one input beat dropped.
- overflow_clr  in  1  synchronous clear of overflow and drop_count.
- drop_count  out  CNT_W  number of dropped beats (saturating).
- frame_words  out  CNT_W  word count of the most recently completed frame.
- frame_done  out  1  one-cycle pulse when a tlast beat is accepted.

Behaviour:
- Reset (aresetn low, asynchronous): FIFO empty.
  - level=0, m_tvalid=0, m_tlast=0, m_tdata=0.
  - almost_full=0, overflow=0, drop_count=0, frame_words=0, frame_done=0.
  - Internal frame counter=0.
  - Reset mid-frame discards all stored data. The next accepted beat starts a new frame.
- Storage: DEPTH=2^DEPTH_LOG entries of {tlast, tdata}. Read/write pointers are DEPTH_LOG bits and wrap modulo DEPTH.
- Accept rule: an input beat is written when in_tvalid=1 and (level < DEPTH or pop occurs this cycle). pop = m_tvalid & m_tready.
- Drop rule: in_tvalid=1, level=DEPTH, no pop:
  - beat discarded, overflow<=1, drop_count<=drop_count+1 (saturates at all-ones).
  - A dropped tlast beat does not complete a frame; the frame counter continues into the next frame.
- Output: first-word-fall-through, registered.
  - A beat accepted in cycle N with an empty FIFO gives m_tvalid=1 in cycle N+1.
  - m_tdata/m_tlast stay stable while m_tvalid=1 and m_tready=0.
  - m_tvalid=0 whenever level=0.
- level updates next cycle: +1 on accept only, -1 on pop only, unchanged on both or neither.
- almost_full is registered from the next-state level: 1 when DEPTH-level <= AF_MARGIN.
- Frame accounting counts accepted beats only:
  - On accept with in_tlast=1: frame_words<=counter+1, counter<=0, frame_done=1 for exactly one cycle.
  - Otherwise on accept: counter<=counter+1.
  - Counter wraps at 2^CNT_W.
- overflow_clr=1: overflow<=0, drop_count<=0. If a drop occurs in the same cycle, the drop wins (overflow=1, drop_count=1).
- No combinational path from in_* to m_*. m_tready->m_tvalid is registered only.

Test Plan:
- Passthrough: m_tready=1, 10 consecutive beats 0..9, tlast on 9 -> m_tdata 0..9 one cycle later, m_tlast on 9, frame_done pulse once, frame_words=10, level<=1 throughout, overflow=0.
- Fill/overflow: DEPTH_LOG=5, m_tready=0, 35 beats -> level=32, almost_full=1 from level 28, overflow=1, drop_count=3. Then m_tready=1 -> beats 0..31 emitted in order.
- Full with simultaneous pop: level=32, in_tvalid=1 and m_tready=1 for 5 cycles -> no drops, level stays 32, output order preserved.
- Frame counting under backpressure: frames of 7 and 3 beats, m_tready toggling 1/0 -> frame_words=7 then 3, two frame_done pulses, tlast on output beats 6 and 9.
- overflow_clr: after drop_count=3, pulse overflow_clr -> 0/0. Same-cycle clr plus drop -> overflow=1, drop_count=1.
- Reset mid-frame: 4 beats stored, aresetn low 2 cycles -> m_tvalid=0 and level=0 immediately. Next 2-beat frame gives frame_words=2.

Source files
------------

// File: rtl/ccsds123_out_buffer.sv
// ccsds123_out_buffer: buffers a no-backpressure compressed stream into a FWFT FIFO re-presented as an AXI4-Stream master
// Ports: clk/aresetn (async active-low); in_tdata/in_tvalid/in_tlast from the compressor (no ready);
// m_tdata/m_tvalid/m_tready/m_tlast to the sink; level = occupancy; almost_full when free <= AF_MARGIN;
// overflow/drop_count record dropped beats, cleared by overflow_clr; frame_words/frame_done report completed frames.
module ccsds123_out_buffer #(
  parameter int BUS_WIDTH = 64,
  parameter int DEPTH_LOG = 5,
  parameter int AF_MARGIN = 4,
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic [BUS_WIDTH-1:0] in_tdata,
  input  logic                 in_tvalid,
  input  logic                 in_tlast,
  output logic [BUS_WIDTH-1:0] m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 m_tlast,
  output logic [DEPTH_LOG:0]   level,
  output logic                 almost_full,
  output logic                 overflow,
  input  logic                 overflow_clr,
  output logic [CNT_W-1:0]     drop_count,
  output logic [CNT_W-1:0]     frame_words,
  output logic                 frame_done
);
  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam int LW = DEPTH_LOG + 1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  logic [BUS_WIDTH:0] mem [DEPTH];
  logic [DEPTH_LOG-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_nxt;
  logic [CNT_W-1:0] frame_cnt, drop_inc;
  logic full, pop, push, drop;
  always_comb begin
    full = level == LW'(DEPTH);
    pop = m_tvalid & m_tready;
    push = in_tvalid & (~full | pop);
    drop = in_tvalid & ~push;
    level_nxt = level + LW'(push) - LW'(pop);
    drop_inc = &drop_count ? drop_count : drop_count + ONE;
  end
  // Head of the FIFO is presented directly from storage; gated to zero while empty.
  assign m_tvalid = level != '0;
  assign {m_tlast, m_tdata} = m_tvalid ? mem[rd_ptr] : '0;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {in_tlast, in_tdata};
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      almost_full <= 1'b0;
      overflow <= 1'b0;
      drop_count <= '0;
      frame_cnt <= '0;
      frame_words <= '0;
      frame_done <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + DEPTH_LOG'(push);
      rd_ptr <= rd_ptr + DEPTH_LOG'(pop);
      level <= level_nxt;
      almost_full <= (DEPTH - int'(level_nxt)) <= AF_MARGIN;
      frame_done <= push & in_tlast;
      if (push) frame_cnt <= in_tlast ? '0 : frame_cnt + ONE;
      if (push & in_tlast) frame_words <= frame_cnt + ONE;
      // A drop in the same cycle as a clear takes priority.
      overflow <= drop | (overflow & ~overflow_clr);
      drop_count <= drop ? (overflow_clr ? ONE : drop_inc) : (overflow_clr ? '0 : drop_count);
    end
  end
endmodule

// File: tb/tb_ccsds123_out_buffer.sv
// tb_ccsds123_out_buffer: self-checking bench with vector table, directed corner sequences and a queue-based reference model
module tb_ccsds123_out_buffer;
  localparam int DEPTH = 32;
  localparam int AFM = 4;
  logic clk = 0, aresetn = 0;
  logic [63:0] in_tdata = 0, m_tdata;
  logic in_tvalid = 0, in_tlast = 0, m_tvalid, m_tready = 0, m_tlast;
  logic [5:0] level;
  logic almost_full, overflow, overflow_clr = 0, frame_done;
  logic [31:0] drop_count, frame_words;
  int n_cmp = 0, n_err = 0;
  logic [64:0] q[$];
  logic e_ovf = 0, e_fd = 0, e_af = 0;
  logic [31:0] e_dc = 0, e_fw = 0, e_cnt = 0;
  int out_idx = 0;
  int last_pos[$];

  ccsds123_out_buffer dut (
    .clk(clk), .aresetn(aresetn), .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tlast(in_tlast),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .level(level),
    .almost_full(almost_full), .overflow(overflow), .overflow_clr(overflow_clr), .drop_count(drop_count),
    .frame_words(frame_words), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    e_ovf = 0; e_fd = 0; e_af = 0; e_dc = 0; e_fw = 0; e_cnt = 0;
  endtask

  task automatic model(input logic v, input logic [63:0] d, input logic l, input logic r, input logic c);
    bit pop, acc, drop;
    pop = q.size() > 0 && r;
    acc = v && (q.size() < DEPTH || pop);
    drop = v && !acc;
    if (pop) void'(q.pop_front());
    if (acc) q.push_back({l, d});
    e_fd = acc && l;
    if (acc && l) begin e_fw = e_cnt + 1; e_cnt = 0; end
    else if (acc) e_cnt = e_cnt + 1;
    if (drop) begin e_ovf = 1; e_dc = c ? 1 : (e_dc == 32'hFFFF_FFFF ? e_dc : e_dc + 1); end
    else if (c) begin e_ovf = 0; e_dc = 0; end
    e_af = (DEPTH - q.size()) <= AFM;
  endtask

  task automatic cmp_model();
    chk("level", level, q.size());
    chk("m_tvalid", m_tvalid, q.size() > 0);
    if (q.size() > 0) begin
      chk("m_tdata", m_tdata, q[0][63:0]);
      chk("m_tlast", m_tlast, q[0][64]);
    end
    chk("almost_full", almost_full, e_af);
    chk("overflow", overflow, e_ovf);
    chk("drop_count", drop_count, e_dc);
    chk("frame_words", frame_words, e_fw);
    chk("frame_done", frame_done, e_fd);
  endtask

  task automatic step(input logic v, input logic [63:0] d, input logic l, input logic r, input logic c);
    in_tvalid = v; in_tdata = d; in_tlast = l; m_tready = r; overflow_clr = c;
    if (m_tvalid && r) begin
      if (m_tlast) last_pos.push_back(out_idx);
      out_idx++;
    end
    @(posedge clk);
    model(v, d, l, r, c);
    #1 cmp_model();
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && q.size() > 0; i++) step(0, 0, 0, 1, 0);
    chk("drained", level, 0);
  endtask

  typedef struct {
    logic v; logic [63:0] d; logic l; logic r;
    int lvl; logic val; logic [63:0] dat; logic lst; logic fd; logic [31:0] fw;
  } vec_t;
  vec_t tbl[11];

  initial begin
    int fd_cnt;
    logic [31:0] fw_seen;
    for (int i = 0; i < 10; i++)
      tbl[i] = '{1'b1, 64'(i), i == 9, 1'b1, 1, 1'b1, 64'(i), i == 9, i == 9, (i == 9) ? 32'd10 : 32'd0};
    tbl[10] = '{1'b0, 64'd0, 1'b0, 1'b1, 0, 1'b0, 64'd0, 1'b0, 1'b0, 32'd10};

    #12;
    chk("rst_level", level, 0);
    chk("rst_valid", m_tvalid, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_dc", drop_count, 0);
    chk("rst_fw", frame_words, 0);
    chk("rst_fd", frame_done, 0);
    @(posedge clk); #1 aresetn = 1;

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r, 0);
      chk($sformatf("tbl%0d_level", i), level, tbl[i].lvl);
      chk($sformatf("tbl%0d_valid", i), m_tvalid, tbl[i].val);
      if (tbl[i].val) begin
        chk($sformatf("tbl%0d_tdata", i), m_tdata, tbl[i].dat);
        chk($sformatf("tbl%0d_tlast", i), m_tlast, tbl[i].lst);
      end
      chk($sformatf("tbl%0d_fd", i), frame_done, tbl[i].fd);
      chk($sformatf("tbl%0d_fw", i), frame_words, tbl[i].fw);
      chk($sformatf("tbl%0d_ovf", i), overflow, 0);
    end

    out_idx = 0; last_pos.delete(); fd_cnt = 0; fw_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 64'(200 + i), i == 6 || i == 9, i[0] == 0, 0);
      if (frame_done) begin fd_cnt++; fw_seen = frame_words; if (fd_cnt == 1) chk("frame1_words", frame_words, 7); end
    end
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 0, i[0] == 0, 0);
      if (frame_done) fd_cnt++;
    end
    chk("frame_pulses", fd_cnt, 2);
    chk("frame2_words", fw_seen, 3);
    chk("last_count", last_pos.size(), 2);
    if (last_pos.size() == 2) begin
      chk("last_pos0", last_pos[0], 6);
      chk("last_pos1", last_pos[1], 9);
    end

    for (int i = 0; i < 35; i++) begin
      step(1, 64'(i), 0, 0, 0);
      if (i == 26) chk("af_at_27", almost_full, 0);
      if (i == 27) chk("af_at_28", almost_full, 1);
    end
    chk("fill_level", level, 32);
    chk("fill_ovf", overflow, 1);
    chk("fill_dc", drop_count, 3);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("fullpop%0d_head", i), m_tdata, 64'(i));
      step(1, 64'(500 + i), 0, 1, 0);
      chk($sformatf("fullpop%0d_level", i), level, 32);
    end
    chk("fullpop_dc", drop_count, 3);
    step(0, 0, 0, 0, 1);
    chk("clr_ovf", overflow, 0);
    chk("clr_dc", drop_count, 0);
    step(1, 64'hDEAD, 0, 0, 1);
    chk("clrdrop_ovf", overflow, 1);
    chk("clrdrop_dc", drop_count, 1);
    drain();

    for (int i = 0; i < 4; i++) step(1, 64'(700 + i), 0, 0, 0);
    #2 aresetn = 0;
    #1;
    chk("arst_level", level, 0);
    chk("arst_valid", m_tvalid, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 aresetn = 1;
    step(1, 64'h11, 0, 0, 0);
    step(1, 64'h22, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("post_rst_fw", frame_words, 2);
    drain();

    for (int b = 0; b < 6; b++) begin
      int rp;
      rp = $urandom_range(1, 9);
      for (int i = 0; i < 500; i++)
        step($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 7) == 0,
             $urandom_range(0, 9) < rp, $urandom_range(0, 63) == 0);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
